// File: rtl/instr_fetch_window.sv
// Instruction prefetch queue: fetches bytes one per handshake from EIP and presents
// the 7-byte decode window; consume retires bytes, flush redirects the stream.
module instr_fetch_window #(
    parameter int unsigned DEPTH     = 16,
    parameter logic [31:0] RESET_EIP = 32'h00007c00
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            mem_req,
    output logic [31:0]     mem_addr,
    input  logic            mem_ack,
    input  logic [7:0]      mem_rdata,
    output logic [6:0][7:0] memory_eip,
    output logic            window_valid,
    output logic [31:0]     eip,
    input  logic            consume,
    input  logic [2:0]      consume_len,
    input  logic            flush,
    input  logic [31:0]     flush_eip
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t             state_q, state_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [31:0]        eip_q, eip_d;
    logic [31:0]        fill_addr_q, fill_addr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [7:0]         buf_q [DEPTH];

    logic               accept_ack;
    logic               consume_ok;
    logic [CNT_W-1:0]   count_after;

    assign window_valid = (count_q >= CNT_W'(7));

    // A flush cancels the write of a byte acked in the same cycle.
    always_comb begin
        accept_ack  = (state_q == REQ) && mem_ack && !flush;
        consume_ok  = consume && window_valid && (consume_len != 3'd0);
        count_after = count_q + CNT_W'(accept_ack)
                      - (consume_ok ? CNT_W'(consume_len) : CNT_W'(0));
    end

    always_comb begin
        eip_d       = eip_q;
        fill_addr_d = fill_addr_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        if (flush) begin
            eip_d       = flush_eip;
            fill_addr_d = flush_eip;
            count_d     = '0;
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
        end else begin
            count_d = count_after;
            if (accept_ack) begin
                wr_ptr_d    = wr_ptr_q + PTR_W'(1);
                fill_addr_d = fill_addr_q + 32'd1;
            end
            if (consume_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(consume_len);
                eip_d    = eip_q + 32'(consume_len);
            end
        end
    end

    // Next-state logic; mem_addr is loaded only on entry to (or stay in) REQ.
    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        case (state_q)
            IDLE: begin
                if (flush) begin
                    state_d    = REQ;
                    mem_addr_d = flush_eip;
                end else if (count_q < DEPTH_C) begin
                    state_d    = REQ;
                    mem_addr_d = fill_addr_q;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    if (flush) begin
                        mem_addr_d = flush_eip;
                    end else if (count_after < DEPTH_C) begin
                        mem_addr_d = fill_addr_q + 32'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (flush) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (mem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req  = (state_q != IDLE);
        mem_addr = mem_addr_q;
        eip      = eip_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_addr_q  <= '0;
            eip_q       <= RESET_EIP;
            fill_addr_q <= RESET_EIP;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            eip_q       <= eip_d;
            fill_addr_q <= fill_addr_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept_ack) begin
            buf_q[wr_ptr_q] <= mem_rdata;
        end
    end

    // Bytes beyond the current fill level read as zero.
    always_comb begin
        for (int i = 0; i < 7; i++) begin
            memory_eip[i] = (CNT_W'(i) < count_q) ? buf_q[rd_ptr_q + PTR_W'(i)] : 8'h00;
        end
    end
endmodule

// File: tb/tb_instr_fetch_window.sv
// Bench for instr_fetch_window: byte-queue reference model feeding a scoreboard,
// directed scenarios followed by randomized consume/flush/ack-delay traffic.
`timescale 1ns/1ps
module tb_instr_fetch_window;
    localparam int          DEPTH     = 16;
    localparam logic [31:0] RESET_EIP = 32'h00007c00;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            mem_req;
    logic [31:0]     mem_addr;
    logic            mem_ack = 1'b0;
    logic [7:0]      mem_rdata = 8'h00;
    logic [6:0][7:0] memory_eip;
    logic            window_valid;
    logic [31:0]     eip;
    logic            consume = 1'b0;
    logic [2:0]      consume_len = 3'd0;
    logic            flush = 1'b0;
    logic [31:0]     flush_eip = 32'h0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    instr_fetch_window #(.DEPTH(DEPTH), .RESET_EIP(RESET_EIP)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .memory_eip(memory_eip), .window_valid(window_valid), .eip(eip),
        .consume(consume), .consume_len(consume_len),
        .flush(flush), .flush_eip(flush_eip)
    );

    typedef struct packed {
        logic            req;
        logic [31:0]     addr;
        logic [31:0]     eip;
        logic            wv;
        logic [6:0][7:0] win;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e, me;
    logic [7:0]  m_q[$];
    logic [31:0] m_eip, m_fill, m_addr;
    logic        m_busy, m_drop;
    int          old_sz;
    logic        ack_now, cok;

    int          ack_delay = 0;
    int          wait_cnt  = 0;
    int          ack_count = 0;
    bit          rand_delay = 1'b0;
    logic [31:0] acked_addrs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: the queue is a list of bytes, eip is the address of its head.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            exp_q.delete();
            m_eip  = RESET_EIP;
            m_fill = RESET_EIP;
            m_addr = 32'h0;
            m_busy = 1'b0;
            m_drop = 1'b0;
        end else begin
            ack_now = m_busy && mem_ack;
            old_sz  = m_q.size();
            cok     = consume && (old_sz >= 7) && (consume_len != 3'd0);
            if (flush) begin
                m_q.delete();
                m_eip  = flush_eip;
                m_fill = flush_eip;
                if (m_busy && !ack_now) begin
                    m_drop = 1'b1;
                end else if (m_drop) begin
                    m_busy = 1'b0;
                    m_drop = 1'b0;
                end else begin
                    m_busy = 1'b1;
                    m_addr = flush_eip;
                end
            end else begin
                if (ack_now && !m_drop) begin
                    m_q.push_back(m_addr[7:0]);
                    m_fill = m_fill + 32'd1;
                end
                if (cok) begin
                    for (int k = 0; k < int'(consume_len); k++) void'(m_q.pop_front());
                    m_eip = m_eip + 32'(consume_len);
                end
                if (ack_now) begin
                    if (m_drop) begin
                        m_busy = 1'b0;
                        m_drop = 1'b0;
                    end else if (m_q.size() < DEPTH) begin
                        m_addr = m_fill;
                    end else begin
                        m_busy = 1'b0;
                    end
                end else if (!m_busy && old_sz < DEPTH) begin
                    m_busy = 1'b1;
                    m_addr = m_fill;
                end
            end
            e.req  = m_busy;
            e.addr = m_addr;
            e.eip  = m_eip;
            e.wv   = (m_q.size() >= 7);
            for (int k = 0; k < 7; k++) e.win[k] = (k < m_q.size()) ? m_q[k] : 8'h00;
            exp_q.push_back(e);
        end
    end

    always @(negedge clk) begin
        if (rst_n && exp_q.size() > 0) begin
            me = exp_q.pop_front();
            chk("sb_mem_req", mem_req, me.req);
            if (me.req) chk("sb_mem_addr", mem_addr, me.addr);
            chk("sb_eip", eip, me.eip);
            chk("sb_window_valid", window_valid, me.wv);
            chk("sb_memory_eip", memory_eip, me.win);
        end
    end

    // One cycle: drive the memory response and clear the one-shot controls.
    task automatic step();
        @(negedge clk);
        consume     = 1'b0;
        consume_len = 3'd0;
        flush       = 1'b0;
        if (!rst_n) wait_cnt = 0;
        if (mem_req && rst_n) begin
            if (wait_cnt >= ack_delay) begin
                mem_ack  = 1'b1;
                wait_cnt = 0;
                ack_count++;
                acked_addrs.push_back(mem_addr);
                if (rand_delay) ack_delay = $urandom_range(0, 3);
            end else begin
                mem_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            mem_ack = 1'b0;
        end
        mem_rdata = mem_addr[7:0];
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        int cyc;
        int req_cyc;
        int wv_cyc;
        logic [31:0] old_addr;

        step();
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_window_valid", window_valid, 1'b0);
        chk("rst_eip", eip, RESET_EIP);
        chk("rst_memory_eip", memory_eip, 56'h0);
        step();
        rst_n = 1'b1;
        ack_count = 0;

        // Reset release with zero-wait memory.
        req_cyc = 0;
        wv_cyc  = 0;
        for (cyc = 1; cyc <= 20 && wv_cyc == 0; cyc++) begin
            step();
            if (mem_req && req_cyc == 0) begin
                req_cyc = cyc;
                chk("first_mem_addr", mem_addr, 32'h00007c00);
            end
            if (window_valid && wv_cyc == 0) begin
                wv_cyc = cyc;
                chk("first_window", memory_eip, 56'h06050403020100);
            end
        end
        chk("first_req_cycle", req_cyc, 1);
        chk("window_valid_cycle", wv_cyc, 8);

        // Fill to full.
        guard = 0;
        while (mem_req && guard < 40) begin step(); guard++; end
        chk("full_ack_count", ack_count, 16);
        chk("full_mem_req", mem_req, 1'b0);
        consume = 1'b1; consume_len = 3'd3;
        step();
        chk("consume3_eip", eip, 32'h00007c03);
        step();
        chk("refetch_req", mem_req, 1'b1);
        chk("refetch_addr", mem_addr, 32'h00007c10);

        // Consume 5 together with an ack at count 9, then an ignored consume 7.
        guard = 0;
        while (mem_req && guard < 40) begin step(); guard++; end
        consume = 1'b1; consume_len = 3'd7;
        guard = 0;
        do begin step(); guard++; end while (!(m_q.size() == 9 && mem_ack) && guard < 40);
        consume = 1'b1; consume_len = 3'd5;
        step();
        chk("cons5_wv_drop", window_valid, 1'b0);
        chk("cons5_eip", eip, 32'h00007c0f);
        guard = 0;
        while (m_q.size() != 6 && guard < 40) begin step(); guard++; end
        consume = 1'b1; consume_len = 3'd7;
        step();
        chk("cons7_ignored_eip", eip, 32'h00007c0f);

        // Flush while a request is stalled.
        ack_delay = 3;
        guard = 0;
        do begin step(); guard++; end while (!(mem_req && !mem_ack) && guard < 40);
        old_addr  = mem_addr;
        flush     = 1'b1;
        flush_eip = 32'h00001000;
        step();
        chk("flush_eip_now", eip, 32'h00001000);
        chk("drop_req_held", mem_req, 1'b1);
        chk("drop_addr_held", mem_addr, old_addr);
        guard = 0;
        while (!mem_ack && guard < 20) begin step(); guard++; end
        step();
        chk("drop_then_idle", mem_req, 1'b0);
        guard = 0;
        do begin step(); guard++; end while (!mem_req && guard < 20);
        chk("post_drop_addr", mem_addr, 32'h00001000);

        // Flush near the top of the address space.
        ack_delay = 0;
        step();
        acked_addrs.delete();
        flush = 1'b1;
        flush_eip = 32'hfffffffd;
        guard = 0;
        do begin step(); guard++; end while (!window_valid && guard < 20);
        chk("wrap_seq_len", (acked_addrs.size() >= 5), 1'b1);
        if (acked_addrs.size() >= 5) begin
            chk("wrap_addr0", acked_addrs[0], 32'hfffffffd);
            chk("wrap_addr1", acked_addrs[1], 32'hfffffffe);
            chk("wrap_addr2", acked_addrs[2], 32'hffffffff);
            chk("wrap_addr3", acked_addrs[3], 32'h00000000);
            chk("wrap_addr4", acked_addrs[4], 32'h00000001);
        end
        consume = 1'b1; consume_len = 3'd4;
        step();
        chk("wrap_eip", eip, 32'h00000001);

        // Randomized traffic.
        rand_delay = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            step();
            if ($urandom_range(0, 59) == 0) begin
                flush     = 1'b1;
                flush_eip = $urandom_range(0, 1) ? $urandom : (32'hfffffff0 + $urandom_range(0, 15));
            end else if ($urandom_range(0, 9) < 4) begin
                consume     = 1'b1;
                consume_len = 3'($urandom_range(0, 7));
            end
        end

        // Reset mid-request.
        rand_delay = 1'b0;
        ack_delay  = 2;
        guard = 0;
        do begin step(); guard++; end while (!mem_req && guard < 40);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_mem_req", mem_req, 1'b0);
        chk("async_rst_wv", window_valid, 1'b0);
        chk("async_rst_eip", eip, RESET_EIP);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("rerelease_eip", eip, 32'h00007c00);
        chk("rerelease_req", mem_req, 1'b1);
        chk("rerelease_addr", mem_addr, 32'h00007c00);
        for (int n = 0; n < 30; n++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
